// File: rtl/vga_sync_gen.sv
// ============================================================================
// Module   : vga_sync_gen
// Function : VGA 640x480@60 raster timing (hsync/vsync/video_on/coordinates),
//            advancing one pixel per pix_en strobe in the clk50M domain.
//            Optional frame counter enabled by macro VGA_FRAME_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk50M,
    input  logic       rst_n,
    input  logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int         H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int         V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       vid_q, vid_d;
    logic       fs_q, wrap_d;

    // Decode from the next counter values so syncs line up with the coordinates.
    always_comb begin
        x_d    = x_q + 10'd1;
        y_d    = y_q;
        wrap_d = 1'b0;
        if (x_q == H_LAST) begin
            x_d = 10'd0;
            if (y_q == V_LAST) begin
                y_d    = 10'd0;
                wrap_d = 1'b1;
            end else begin
                y_d = y_q + 10'd1;
            end
        end
        hs_d  = ((x_d >= HS_START) && (x_d <= HS_END)) ? SYNC_POL : ~SYNC_POL;
        vs_d  = ((y_d >= VS_START) && (y_d <= VS_END)) ? SYNC_POL : ~SYNC_POL;
        vid_d = (x_d < H_VIS) && (y_d < V_VIS);
    end

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= H_LAST;
            y_q   <= V_LAST;
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
            vid_q <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            fs_q <= 1'b0;
            if (pix_en) begin
                x_q   <= x_d;
                y_q   <= y_d;
                hs_q  <= hs_d;
                vs_q  <= vs_d;
                vid_q <= vid_d;
                fs_q  <= wrap_d;
            end
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 8'd0;
        end else if (pix_en && wrap_d) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 8'd0;
`endif

    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign video_on    = vid_q;
    assign frame_start = fs_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
// ============================================================================
// Module   : tb_vga_sync_gen
// Function : Directed self-checking bench for vga_sync_gen (default timing
//            instance plus a reduced-timing instance for whole-frame runs).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_sync_gen;

    // Reduced raster: 15 pixels x 8 lines, hsync 10..12, vsync lines 5..6
    localparam int HB_ACT = 8, HB_FP = 2, HB_SY = 3, HB_BP = 2;
    localparam int VB_ACT = 4, VB_FP = 1, VB_SY = 2, VB_BP = 1;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst_a_n, en_a, hs_a, vs_a, vid_a, fs_a;
    logic [9:0] x_a, y_a;
    logic [7:0] fc_a;
    logic       rst_b_n, en_b, hs_b, vs_b, vid_b, fs_b;
    logic [9:0] x_b, y_b;
    logic [7:0] fc_b;

    vga_sync_gen u_dut (
        .clk50M(clk), .rst_n(rst_a_n), .pix_en(en_a),
        .hsync(hs_a), .vsync(vs_a), .video_on(vid_a),
        .pixel_x(x_a), .pixel_y(y_a), .frame_start(fs_a), .frame_cnt(fc_a)
    );

    vga_sync_gen #(
        .H_ACTIVE(HB_ACT), .H_FP(HB_FP), .H_SYNC(HB_SY), .H_BP(HB_BP),
        .V_ACTIVE(VB_ACT), .V_FP(VB_FP), .V_SYNC(VB_SY), .V_BP(VB_BP),
        .SYNC_POL(1'b0)
    ) u_small (
        .clk50M(clk), .rst_n(rst_b_n), .pix_en(en_b),
        .hsync(hs_b), .vsync(vs_b), .video_on(vid_b),
        .pixel_x(x_b), .pixel_y(y_b), .frame_start(fs_b), .frame_cnt(fc_b)
    );

    // {x[31:22], y[21:12], hsync[11], vsync[10], video_on[9], frame_start[8], frame_cnt[7:0]}
    wire [31:0] obs_a = {x_a, y_a, hs_a, vs_a, vid_a, fs_a, fc_a};
    wire [31:0] obs_b = {x_b, y_b, hs_b, vs_b, vid_b, fs_b, fc_b};

    int n_vec = 0;
    int n_err = 0;
    int ax, ay, afr, bx, by, bfr;
    logic afs, bfs;
    logic [31:0] seq[$];

    function automatic logic [31:0] expv(input int x, input int y, input int fr,
                                         input int hact, input int hs0, input int hs1,
                                         input int vact, input int vs0, input int vs1,
                                         input logic fs);
        logic hs, vs, vid;
        logic [7:0] fc;
        hs  = (x >= hs0 && x <= hs1) ? 1'b0 : 1'b1;
        vs  = (y >= vs0 && y <= vs1) ? 1'b0 : 1'b1;
        vid = (x < hact) && (y < vact);
`ifdef VGA_FRAME_CNT_EN
        fc = 8'(fr);
`else
        fc = 8'd0;
`endif
        return {10'(x), 10'(y), hs, vs, vid, fs, fc};
    endfunction

    function automatic logic [31:0] exp_a(input int x, input int y, input int fr, input logic fs);
        return expv(x, y, fr, 640, 656, 751, 480, 490, 491, fs);
    endfunction

    function automatic logic [31:0] exp_b(input int x, input int y, input int fr, input logic fs);
        return expv(x, y, fr, HB_ACT, 10, 12, VB_ACT, 5, 6, fs);
    endfunction

    task automatic adv_a();
        if (ax == 799) begin ax = 0; ay = (ay == 524) ? 0 : ay + 1; end
        else ax = ax + 1;
        afs = (ax == 0 && ay == 0);
        if (afs) afr = afr + 1;
    endtask

    task automatic adv_b();
        if (bx == 14) begin bx = 0; by = (by == 7) ? 0 : by + 1; end
        else bx = bx + 1;
        bfs = (bx == 0 && by == 0);
        if (bfs) bfr = bfr + 1;
    endtask

    task automatic strobe_a();
        @(negedge clk) en_a = 1'b1;
        @(negedge clk) en_a = 1'b0;
    endtask

    task automatic strobe_b();
        @(negedge clk) en_b = 1'b1;
        @(negedge clk) en_b = 1'b0;
    endtask

    task automatic reset_a();
        @(negedge clk) rst_a_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_a_n = 1'b1;
        ax = 799; ay = 524; afr = 0;
    endtask

    task automatic reset_b();
        @(negedge clk) rst_b_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_b_n = 1'b1;
        bx = 14; by = 7; bfr = 0;
    endtask

    task automatic test_reset();
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        en_a = 1'b1; en_b = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if (obs_a !== {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
            n_err++;
            $display("FAIL reset_default: got %h want %h", obs_a,
                     {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
        end
        n_vec++;
        if (obs_b !== {10'd14, 10'd7, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
            n_err++;
            $display("FAIL reset_small: got %h want %h", obs_b,
                     {10'd14, 10'd7, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
        end
        en_a = 1'b0; en_b = 1'b0;
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        ax = 799; ay = 524; afr = 0;
        bx = 14; by = 7; bfr = 0;
    endtask

    task automatic test_first_pixel();
        strobe_a();
        adv_a();
        n_vec++;
        if (obs_a !== exp_a(0, 0, 1, 1'b1)) begin
            n_err++;
            $display("FAIL first_pixel: got %h want %h", obs_a, exp_a(0, 0, 1, 1'b1));
        end
        @(negedge clk);
        n_vec++;
        if (obs_a !== exp_a(0, 0, 1, 1'b0)) begin
            n_err++;
            $display("FAIL frame_start_width: got %h want %h", obs_a, exp_a(0, 0, 1, 1'b0));
        end
    endtask

    task automatic test_line();
        int hs_low = 0;
        int vid_fall = -1;
        for (int k = 1; k <= 800; k++) begin
            strobe_a();
            adv_a();
            n_vec++;
            if (obs_a !== exp_a(ax, ay, afr, afs)) begin
                n_err++;
                $display("FAIL line_step k=%0d: got %h want %h", k, obs_a, exp_a(ax, ay, afr, afs));
            end
            if (hs_a === 1'b0) hs_low++;
            if (vid_fall < 0 && vid_a === 1'b0) vid_fall = int'(x_a);
        end
        n_vec++;
        if (hs_low != 96) begin
            n_err++;
            $display("FAIL hsync_width: got %0d want 96", hs_low);
        end
        n_vec++;
        if (vid_fall != 640) begin
            n_err++;
            $display("FAIL video_on_fall: got %0d want 640", vid_fall);
        end
    endtask

    task automatic test_continuous();
        @(negedge clk) en_a = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            adv_a();
            n_vec++;
            if (obs_a !== exp_a(ax, ay, afr, afs)) begin
                n_err++;
                $display("FAIL continuous k=%0d: got %h want %h", k, obs_a, exp_a(ax, ay, afr, afs));
            end
        end
        en_a = 1'b0;
    endtask

    task automatic test_frame_small();
        int last_fs = -1;
        for (int k = 0; k < 241; k++) begin
            strobe_b();
            adv_b();
            seq.push_back(obs_b);
            n_vec++;
            if (obs_b !== exp_b(bx, by, bfr, bfs)) begin
                n_err++;
                $display("FAIL frame_step k=%0d: got %h want %h", k, obs_b, exp_b(bx, by, bfr, bfs));
            end
            if (fs_b === 1'b1) begin
                if (last_fs >= 0) begin
                    n_vec++;
                    if (k - last_fs != 120) begin
                        n_err++;
                        $display("FAIL frame_period: got %0d want 120", k - last_fs);
                    end
                end
                last_fs = k;
            end
        end
    endtask

    task automatic test_gaps();
        int gap;
        reset_b();
        for (int i = 0; i < 241; i++) begin
            strobe_b();
            n_vec++;
            if (obs_b !== seq[i]) begin
                n_err++;
                $display("FAIL gap_seq i=%0d: got %h want %h", i, obs_b, seq[i]);
            end
            gap = int'($urandom_range(1, 5));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                n_vec++;
                if (obs_b !== {seq[i][31:9], 1'b0, seq[i][7:0]}) begin
                    n_err++;
                    $display("FAIL gap_hold i=%0d: got %h want %h", i, obs_b,
                             {seq[i][31:9], 1'b0, seq[i][7:0]});
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        reset_a();
        @(negedge clk) en_a = 1'b1;
        repeat (301) @(negedge clk);
        en_a = 1'b0;
        n_vec++;
        if (x_a !== 10'd300 || y_a !== 10'd0) begin
            n_err++;
            $display("FAIL midframe_pos_a: got %0d,%0d want 300,0", x_a, y_a);
        end
        #3 rst_a_n = 1'b0;
        #1;
        n_vec++;
        if (obs_a !== {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
            n_err++;
            $display("FAIL async_reset_a: got %h want %h", obs_a,
                     {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
        end
        @(negedge clk) rst_a_n = 1'b1;
        strobe_a();
        n_vec++;
        if (obs_a !== exp_a(0, 0, 1, 1'b1)) begin
            n_err++;
            $display("FAIL restart_a: got %h want %h", obs_a, exp_a(0, 0, 1, 1'b1));
        end

        reset_b();
        @(negedge clk) en_b = 1'b1;
        repeat (51) @(negedge clk);
        en_b = 1'b0;
        n_vec++;
        if (obs_b !== exp_b(5, 3, 1, 1'b0)) begin
            n_err++;
            $display("FAIL midframe_pos_b: got %h want %h", obs_b, exp_b(5, 3, 1, 1'b0));
        end
        #3 rst_b_n = 1'b0;
        #1;
        n_vec++;
        if (obs_b !== {10'd14, 10'd7, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
            n_err++;
            $display("FAIL async_reset_b: got %h want %h", obs_b,
                     {10'd14, 10'd7, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
        end
        @(negedge clk) rst_b_n = 1'b1;
        strobe_b();
        n_vec++;
        if (obs_b !== exp_b(0, 0, 1, 1'b1)) begin
            n_err++;
            $display("FAIL restart_b: got %h want %h", obs_b, exp_b(0, 0, 1, 1'b1));
        end
    endtask

    task automatic test_frame_cnt();
`ifdef VGA_FRAME_CNT_EN
        localparam int FRAMES = 257;
        localparam logic [7:0] FC_END = 8'd1;
`else
        localparam int FRAMES = 3;
        localparam logic [7:0] FC_END = 8'd0;
`endif
        reset_b();
        @(negedge clk) en_b = 1'b1;
        for (int k = 0; k < 1 + (FRAMES - 1) * 120; k++) begin
            @(negedge clk);
            adv_b();
            n_vec++;
            if (obs_b !== exp_b(bx, by, bfr, bfs)) begin
                n_err++;
                $display("FAIL frame_cnt_step k=%0d: got %h want %h", k, obs_b, exp_b(bx, by, bfr, bfs));
            end
        end
        en_b = 1'b0;
        n_vec++;
        if (fc_b !== FC_END || fs_b !== 1'b1) begin
            n_err++;
            $display("FAIL frame_cnt_final: got %0d fs=%b want %0d fs=1", fc_b, fs_b, FC_END);
        end
    endtask

    initial begin
        rst_a_n = 1'b0; rst_b_n = 1'b0; en_a = 1'b0; en_b = 1'b0;
        test_reset();
        test_first_pixel();
        test_line();
        test_continuous();
        test_frame_small();
        test_gaps();
        test_reset_midframe();
        test_frame_cnt();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
